muldiv_ctrl: RTL and testbench

Sequencer for the multi-cycle multiply/divide path behind the ALU "*" and "/" control codes in the 5-stage pipeline. It accepts one mult/multu/div/divu request and runs a fixed-latency multiplier or a 32-step restoring divider. It owns the HI/LO architectural registers and raises busy so the pipeline can stall until done. EX-stage flush aborts an in-flight operation without touching HI/LO.

---
 rtl/muldiv_ctrl.sv | 141 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO multiply/divide sequencer with flush abort and mthi/mtlo writes.
// Optional MULDIV_EARLY_OUT_EN: a divide with |dividend| < |divisor| finishes without iterating.
module muldiv_ctrl #(
    parameter int MUL_LATENCY = 2,
    parameter int DIV_STEPS   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flush_i,
    input  logic        mthi_i,
    input  logic        mtlo_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam logic [4:0] MUL_CNT = 5'(MUL_LATENCY - 1);
    localparam logic [4:0] DIV_CNT = 5'(DIV_STEPS - 1);

    state_t      state;
    logic [4:0]  count;
    logic        mul_uns;
    logic [31:0] a_q, b_q;
    logic [31:0] quo, dvs, rem;
    logic        qneg, rneg;

    logic        in_signed;
    logic [31:0] a_mag, b_mag;
    logic [63:0] prod;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] rem_next, quo_next, q_fix, r_fix;

    assign busy_o = (state == S_MUL) || (state == S_DIV);
    assign done_o = (state == S_DONE);

    assign in_signed = ~op_i[0];
    assign a_mag = (in_signed && a_i[31]) ? -a_i : a_i;
    assign b_mag = (in_signed && b_i[31]) ? -b_i : b_i;

    // Sign-extending to 64 bits makes the truncated product the correct signed result.
    assign prod = mul_uns ? ({32'b0, a_q} * {32'b0, b_q})
                          : ({{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q});

    // Restoring step: the true remainder always fits 32 bits, only the trial needs 33.
    assign shifted  = {rem, quo[31]};
    assign ge       = shifted[32] || (shifted[31:0] >= dvs);
    assign rem_next = ge ? (shifted[31:0] - dvs) : shifted[31:0];
    assign quo_next = {quo[30:0], ge};
    assign q_fix    = qneg ? -quo_next : quo_next;
    assign r_fix    = rneg ? -rem_next : rem_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= '0;
            mul_uns <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            quo     <= '0;
            dvs     <= '0;
            rem     <= '0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // Move-to writes come first so an accepted op's result overrides them.
                    if (mthi_i) hi_o <= wdata_i;
                    if (mtlo_i) lo_o <= wdata_i;
                    if (start_i && !flush_i) begin
                        mul_uns <= op_i[0];
                        a_q     <= a_i;
                        b_q     <= b_i;
                        quo     <= a_mag;
                        dvs     <= b_mag;
                        rem     <= '0;
                        qneg    <= in_signed && (a_i[31] ^ b_i[31]);
                        rneg    <= in_signed && a_i[31];
                        if (!op_i[1]) begin
                            state <= S_MUL;
                            count <= MUL_CNT;
                        end else if (b_i == 32'd0) begin
                            state <= S_DONE;
                            hi_o  <= a_i;
                            lo_o  <= 32'hFFFF_FFFF;
`ifdef MULDIV_EARLY_OUT_EN
                        end else if (a_mag < b_mag) begin
                            state <= S_DONE;
                            hi_o  <= a_i;
                            lo_o  <= 32'd0;
`endif
                        end else begin
                            state <= S_DIV;
                            count <= DIV_CNT;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                    end else if (count == 5'd0) begin
                        {hi_o, lo_o} <= prod;
                        state        <= S_DONE;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                S_DIV: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        if (count == 5'd0) begin
                            hi_o  <= r_fix;
                            lo_o  <= q_fix;
                            state <= S_DONE;
                        end else begin
                            count <= count - 5'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - vector table, random model and corner sequences for muldiv_ctrl.
module tb_muldiv_ctrl;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO = 1;
`else
    localparam int EO = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i, flush_i, mthi_i, mtlo_i;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i, wdata_i;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    muldiv_ctrl dut (
        .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        int          lat;
    } exp_t;

    vec_t        vt[14];
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_fail = 0;
    logic [31:0] last_hi, last_lo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called with inputs driven 1 ns after a rising edge; that cycle is cycle 0.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                         input int lat);
        exp_t e;
        int   cyc;
        bit   got;
        e.hi = hi; e.lo = lo; e.lat = lat;
        sb.push_back(e);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            start_i = 1'b0;
            if (done_o) got = 1'b1;
        end
        e = sb.pop_front();
        if (!got) begin
            n_vec++; n_fail++;
            $display("FAIL %s timeout: no done_o within 80 cycles, expected cycle %0d", name, e.lat);
        end else begin
            chk({name, " latency"}, 32'(cyc), 32'(e.lat));
            chk({name, " hi"}, hi_o, e.hi);
            chk({name, " lo"}, lo_o, e.lo);
        end
        last_hi = e.hi;
        last_lo = e.lo;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        logic signed [63:0] sa, sbv, am, bm;
        logic [63:0]        p;
        logic [1:0]         op;
        logic [31:0]        a, b, ehi, elo;
        int                 lat, dn;

        vt[0]  = '{2'b00, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE, 3};
        vt[1]  = '{2'b01, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 3};
        vt[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vt[3]  = '{2'b11, 32'd100,       32'd7,        32'd2,         32'd14,        33};
        vt[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33};
        vt[5]  = '{2'b11, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1};
        vt[6]  = '{2'b11, 32'd3,         32'd9,        32'd3,         32'd0,         (EO != 0) ? 1 : 33};
        vt[7]  = '{2'b00, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 3};
        vt[8]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        3};
        vt[9]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,        3};
        vt[10] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33};
        vt[11] = '{2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1};
        vt[12] = '{2'b10, 32'h8000_0000, 32'd1,        32'd0,         32'h8000_0000, 33};
        vt[13] = '{2'b11, 32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 33};

        reset = 1'b1; start_i = 1'b0; flush_i = 1'b0; mthi_i = 1'b0; mtlo_i = 1'b0;
        op_i = 2'b00; a_i = '0; b_i = '0; wdata_i = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset hi", hi_o, 32'd0);
        chk("reset lo", lo_o, 32'd0);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);

        // Consecutive ops start in the previous op's DONE cycle (back-to-back).
        for (int i = 0; i < 14; i++)
            do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].lat);

        for (int i = 0; i < 12; i++) begin
            op = 2'(i % 4);
            a = $urandom; b = $urandom;
            if (i >= 8) b = b >> (8 + i);
            if (op[1] && b == 32'd0) b = 32'd1;
            sa  = op[0] ? {32'b0, a} : {{32{a[31]}}, a};
            sbv = op[0] ? {32'b0, b} : {{32{b[31]}}, b};
            if (!op[1]) begin
                p = sa * sbv;
                ehi = p[63:32]; elo = p[31:0]; lat = 3;
            end else begin
                p = sa % sbv; ehi = p[31:0];
                p = sa / sbv; elo = p[31:0];
                am = (sa < 0) ? -sa : sa;
                bm = (sbv < 0) ? -sbv : sbv;
                lat = (EO != 0 && am < bm) ? 1 : 33;
            end
            do_op($sformatf("rnd%0d", i), op, a, b, ehi, elo, lat);
        end

        // Flush a divu at cycle 10; a start at cycle 5 lands while busy and must be ignored.
        start_i = 1'b1; op_i = 2'b11; a_i = 32'd1000; b_i = 32'd3;
        for (int c = 1; c <= 11; c++) begin
            tick();
            start_i = (c == 5);
            if (c == 5) begin op_i = 2'b00; a_i = 32'd2; b_i = 32'd2; end
            if (c == 6) chk("busy after ignored start", 32'(busy_o), 32'd1);
            flush_i = (c == 10);
        end
        chk("flush busy", 32'(busy_o), 32'd0);
        chk("flush done", 32'(done_o), 32'd0);
        chk("flush hi kept", hi_o, last_hi);
        chk("flush lo kept", lo_o, last_lo);
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done_o || busy_o) dn++;
        end
        chk("no activity after flush", 32'(dn), 32'd0);

        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b11; a_i = 32'd50; b_i = 32'd7;
        tick();
        start_i = 1'b0; flush_i = 1'b0;
        chk("start with flush ignored", 32'(busy_o | done_o), 32'd0);

        mthi_i = 1'b1; wdata_i = 32'h1234;
        tick();
        mthi_i = 1'b0;
        chk("mthi", hi_o, 32'h1234);
        mtlo_i = 1'b1; wdata_i = 32'h5678;
        tick();
        mtlo_i = 1'b0;
        chk("mtlo", lo_o, 32'h5678);
        start_i = 1'b1; op_i = 2'b01; a_i = 32'd3; b_i = 32'd4;
        tick();
        start_i = 1'b0; mtlo_i = 1'b1; wdata_i = 32'hDEAD;
        tick();
        mtlo_i = 1'b0;
        chk("mtlo while busy", lo_o, 32'h5678);
        tick();
        chk("mul after mt done", 32'(done_o), 32'd1);
        chk("mul after mt lo", lo_o, 32'd12);
        chk("mul after mt hi", hi_o, 32'd0);

        // Reset at DIV cycle 20 clears everything.
        start_i = 1'b1; op_i = 2'b10; a_i = 32'd1000; b_i = 32'd7;
        for (int c = 1; c <= 20; c++) begin
            tick();
            start_i = 1'b0;
            if (c == 20) reset = 1'b1;
        end
        tick();
        reset = 1'b0;
        chk("mid-div reset hi", hi_o, 32'd0);
        chk("mid-div reset lo", lo_o, 32'd0);
        chk("mid-div reset busy", 32'(busy_o), 32'd0);
        chk("mid-div reset done", 32'(done_o), 32'd0);

        do_op("after reset divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
